// File: rtl/comp_pkg.sv
// Shared types for the sequential comparator: condition codes, FSM states
// and the condition evaluator used once the relation is known.
package comp_pkg;

  typedef enum logic [2:0] {
    OP_EQ = 3'd0,
    OP_NE = 3'd1,
    OP_LT = 3'd2,
    OP_LE = 3'd3,
    OP_GT = 3'd4,
    OP_GE = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Codes 6 and 7 are reserved and always evaluate false.
  function automatic logic cond_eval(input logic [2:0] op, input logic less,
                                     input logic greater, input logic equal);
    logic r;
    case (op)
      OP_EQ:   r = equal;
      OP_NE:   r = !equal;
      OP_LT:   r = less;
      OP_LE:   r = less | equal;
      OP_GT:   r = greater;
      OP_GE:   r = greater | equal;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational unsigned N-bit comparator producing a one-hot relation.
module comp_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         less,
  output logic         greater,
  output logic         equal
);

  assign less    = (a < b);
  assign greater = (a > b);
  assign equal   = (a == b);

endmodule

// File: rtl/comp_seq_n.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per cycle from the MSB,
// stopping at the first unequal chunk, with valid/ready on both sides.
module comp_seq_n
  import comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less,
  output logic             greater,
  output logic             equal,
  output logic             cond,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_e            state, state_n;
  logic [IDXW-1:0]   idx, idx_n;
  logic [WIDTH-1:0]  a_r, b_r;
  logic [2:0]        op_r;
  logic              less_n, greater_n, equal_n, cond_n;
  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic              c_less, c_greater, c_equal;
  logic              accept;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  assign a_chunk = CHUNK'(a_r >> (int'(idx) * CHUNK));
  assign b_chunk = CHUNK'(b_r >> (int'(idx) * CHUNK));

  comp_chunk #(.N(CHUNK)) u_chunk (
    .a       (a_chunk),
    .b       (b_chunk),
    .less    (c_less),
    .greater (c_greater),
    .equal   (c_equal)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    less_n    = less;
    greater_n = greater;
    equal_n   = equal;
    cond_n    = cond;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_SCAN;
          idx_n   = IDX_TOP;
        end
      end
      ST_SCAN: begin
        // An unequal chunk or the last chunk settles the relation.
        if (!c_equal || idx == '0) begin
          less_n    = c_less;
          greater_n = c_greater;
          equal_n   = c_equal;
          cond_n    = cond_eval(op_r, c_less, c_greater, c_equal);
          state_n   = ST_DONE;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          less_n    = 1'b0;
          greater_n = 1'b0;
          equal_n   = 1'b0;
          cond_n    = 1'b0;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      less      <= 1'b0;
      greater   <= 1'b0;
      equal     <= 1'b0;
      cond      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      less      <= less_n;
      greater   <= greater_n;
      equal     <= equal_n;
      cond      <= cond_n;
      out_valid <= (state_n == ST_DONE);
      busy      <= (state_n != ST_IDLE);
      // Flipping the sign bits maps two's complement onto offset binary.
      if (accept) begin
        a_r  <= a ^ (signed_mode ? SIGN_MASK : '0);
        b_r  <= b ^ (signed_mode ? SIGN_MASK : '0);
        op_r <= op;
      end
    end
  end

endmodule

// File: tb/tb_comp_seq_n.sv
// Scoreboard bench for comp_seq_n: a 16/4 scanning instance and an 8/8
// single-cycle instance share the stimulus bus.
module tb_comp_seq_n;
  import comp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        signed_mode = 1'b0;
  logic [2:0]  op = '0;
  logic        out_ready = 1'b1;

  logic iv16 = 1'b0, ir16, ov16, l16, g16, e16, c16, busy16;
  logic iv8  = 1'b0, ir8,  ov8,  l8,  g8,  e8,  c8,  busy8;

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic l, g, e, c;
    int   lat;
    int   acc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  logic prev16 = 1'b0;
  logic prev8  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  comp_seq_n #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a), .b(b), .signed_mode(signed_mode), .op(op),
    .out_valid(ov16), .out_ready(out_ready),
    .less(l16), .greater(g16), .equal(e16), .cond(c16), .busy(busy16)
  );

  comp_seq_n #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .signed_mode(signed_mode), .op(op),
    .out_valid(ov8), .out_ready(out_ready),
    .less(l8), .greater(g8), .equal(e8), .cond(c8), .busy(busy8)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic scoreResult(input string tag, input exp_t e,
                             input logic l, input logic g, input logic eq, input logic c);
    checkOutput({tag, " less"},    int'(l),  int'(e.l));
    checkOutput({tag, " greater"}, int'(g),  int'(e.g));
    checkOutput({tag, " equal"},   int'(eq), int'(e.e));
    checkOutput({tag, " cond"},    int'(c),  int'(e.c));
    checkOutput({tag, " latency"}, cycle - e.acc, e.lat);
  endtask

  // Monitors score each result on the cycle out_valid first rises.
  always @(negedge clk) begin
    if (ov16 && !prev16) begin
      if (q16.size() == 0) checkOutput("dut16 unexpected out_valid", 1, 0);
      else scoreResult("dut16", q16.pop_front(), l16, g16, e16, c16);
    end
    prev16 = ov16;
  end

  always @(negedge clk) begin
    if (ov8 && !prev8) begin
      if (q8.size() == 0) checkOutput("dut8 unexpected out_valid", 1, 0);
      else scoreResult("dut8", q8.pop_front(), l8, g8, e8, c8);
    end
    prev8 = ov8;
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic applyStimulus(input bit sel, input logic [15:0] va, input logic [15:0] vb,
                               input logic sm, input logic [2:0] vop,
                               input logic el, input logic eg, input logic ee, input logic ec,
                               input int elat, input bit track, output int acc);
    int   n;
    exp_t e;
    n = 0;
    a = va;
    b = vb;
    signed_mode = sm;
    op = vop;
    if (sel) iv8 = 1'b1;
    else     iv16 = 1'b1;
    while (!(sel ? ir8 : ir16) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checkOutput("accept timeout", 0, 1);
      acc = -1;
    end else begin
      acc = cycle + 1;
      if (track) begin
        e = '{el, eg, ee, ec, elat, acc};
        if (sel) q8.push_back(e);
        else     q16.push_back(e);
      end
      @(negedge clk);
    end
    iv16 = 1'b0;
    iv8  = 1'b0;
  endtask

  initial begin
    int acc;
    int rel;
    int n;

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", int'(ov16), 0);
    checkOutput("reset less",      int'(l16),  0);
    checkOutput("reset greater",   int'(g16),  0);
    checkOutput("reset equal",     int'(e16),  0);
    checkOutput("reset cond",      int'(c16),  0);
    checkOutput("reset busy",      int'(busy16), 0);
    checkOutput("reset in_ready",  int'(ir16), 0);
    checkOutput("reset in_ready8", int'(ir8),  0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready after reset",  int'(ir16), 1);
    checkOutput("in_ready8 after reset", int'(ir8),  1);
    @(negedge clk);

    //            sel a        b        sm    op     l g e c  lat
    applyStimulus(0, 16'h1234, 16'h1234, 1'b0, OP_EQ, 0, 0, 1, 1, 4, 1, acc);
    applyStimulus(0, 16'h8000, 16'h7FFF, 1'b0, OP_GT, 0, 1, 0, 1, 1, 1, acc);
    applyStimulus(0, 16'h8000, 16'h7FFF, 1'b1, OP_GT, 1, 0, 0, 0, 1, 1, acc);
    applyStimulus(0, 16'h00F1, 16'h00F2, 1'b0, OP_LE, 1, 0, 0, 1, 4, 1, acc);
    applyStimulus(0, 16'h1234, 16'h1334, 1'b0, OP_NE, 1, 0, 0, 1, 2, 1, acc);
    applyStimulus(0, 16'h12A4, 16'h1294, 1'b0, OP_GE, 0, 1, 0, 1, 3, 1, acc);
    applyStimulus(0, 16'hFFFF, 16'hFFFE, 1'b1, OP_LT, 0, 1, 0, 0, 4, 1, acc);
    applyStimulus(0, 16'h5555, 16'h5555, 1'b0, 3'd6,  0, 0, 1, 0, 4, 1, acc);
    applyStimulus(0, 16'hFFFB, 16'h0003, 1'b1, OP_LE, 1, 0, 0, 1, 1, 1, acc);

    // Abort a compare with rst while idx is 2; no result may appear.
    applyStimulus(0, 16'h1111, 16'h1111, 1'b0, OP_EQ, 0, 0, 1, 1, 4, 0, acc);
    @(negedge clk);
    checkOutput("busy before abort", int'(busy16), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort out_valid", int'(ov16), 0);
    checkOutput("abort less",      int'(l16),  0);
    checkOutput("abort greater",   int'(g16),  0);
    checkOutput("abort equal",     int'(e16),  0);
    checkOutput("abort cond",      int'(c16),  0);
    checkOutput("abort busy",      int'(busy16), 0);
    checkOutput("abort in_ready",  int'(ir16), 0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready after abort", int'(ir16), 1);
    repeat (8) @(negedge clk);

    // Backpressure: result held while a new request waits.
    out_ready = 1'b0;
    applyStimulus(0, 16'h4000, 16'h3000, 1'b0, OP_GT, 0, 1, 0, 1, 1, 1, acc);
    a = 16'h0010;
    b = 16'h0020;
    op = OP_LT;
    iv16 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("hold out_valid", int'(ov16), 1);
      checkOutput("hold greater",   int'(g16),  1);
      checkOutput("hold cond",      int'(c16),  1);
      checkOutput("hold in_ready",  int'(ir16), 0);
    end
    out_ready = 1'b1;
    rel = cycle;
    applyStimulus(0, 16'h0010, 16'h0020, 1'b0, OP_LT, 1, 0, 0, 1, 3, 1, acc);
    checkOutput("accept gap after release", acc - rel, 2);

    // Single-cycle configuration.
    applyStimulus(1, 16'h00FF, 16'h0001, 1'b1, OP_GE, 1, 0, 0, 0, 1, 1, acc);
    applyStimulus(1, 16'h00FF, 16'h0001, 1'b1, 3'd7,  1, 0, 0, 0, 1, 1, acc);
    applyStimulus(1, 16'h00FF, 16'h0001, 1'b0, OP_GE, 0, 1, 0, 1, 1, 1, acc);
    applyStimulus(1, 16'h005A, 16'h005A, 1'b1, OP_EQ, 0, 0, 1, 1, 1, 1, acc);

    n = 0;
    while ((q16.size() != 0 || q8.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending dut16 results", q16.size(), 0);
    checkOutput("pending dut8 results",  q8.size(),  0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
